// File: rtl/pl_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pl_hazard_ctrl                                                |
// | Purpose  : Hazard/stall controller for a five-stage RISC-V pipeline.     |
// |            Generates E-stage forwarding selects, hold (Stall*) and       |
// |            clear (Flush*) controls for the pipeline registers, sequences |
// |            variable-latency M-stage memory accesses through a small wait |
// |            FSM and keeps a saturating count of fetch-stall cycles.       |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW   register specifiers       |
// |            RegWriteM/RegWriteW, ResultSrcE, PCSrcE  control from stages  |
// |            MemReqM/MemReadyM                    data-memory handshake    |
// |            ForwardAE/ForwardBE                  forwarding selects       |
// |            StallF/D/E/M, FlushD/E/W             register en/clr controls |
// |            MemErr                               sticky timeout flag      |
// |            StallCnt                             saturating stall count   |
// | Config   : HAZ_MEM_TIMEOUT_EN enables the memory timeout / ERR state.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pl_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt
);

  localparam logic [1:0] LOAD_SRC    = 2'b01;
  localparam logic [7:0] WAIT_MAX    = 8'hFF;
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e           state_q;
  logic [7:0]       wait_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             mem_stall;
  logic             lw_stall;

  // ---------------------------------------------------------------------
  // Forwarding: the younger producer (M) wins over the older one (W).
  // ---------------------------------------------------------------------
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      ForwardBE = 2'b01;
  end

  // ---------------------------------------------------------------------
  // Memory stall. In WAIT the stall drops in the very cycle MemReadyM
  // rises so the M instruction advances on the next edge; a k-cycle
  // wait therefore costs exactly k stall cycles.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      S_WAIT:  mem_stall = !MemReadyM;
      S_ERR:   mem_stall = 1'b1;
      default: mem_stall = MemReqM && !MemReadyM;
    endcase
  end

  // A taken branch squashes the dependent instruction anyway, so no
  // load-use bubble is needed then; a memory stall freezes everything.
  assign lw_stall = !mem_stall && !PCSrcE && (ResultSrcE == LOAD_SRC) &&
                    (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  assign StallF = mem_stall || lw_stall;
  assign StallD = mem_stall || lw_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;
  // A branch seen during a memory stall stays held in E and is acted on
  // once the stall clears.
  assign FlushD = PCSrcE && !mem_stall;
  assign FlushE = (lw_stall || PCSrcE) && !mem_stall;
  // Bubble into W so the held M instruction is not written back twice.
  assign FlushW = mem_stall;

  assign StallCnt    = stall_cnt_q;
  assign stall_cnt_d = (StallF && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

`ifdef HAZ_MEM_TIMEOUT_EN
  logic mem_err_q;
  assign MemErr = mem_err_q;
`else
  logic unused_timeout;
  assign MemErr         = 1'b0;
  assign unused_timeout = ^TIMEOUT_LIM;
`endif

  // ---------------------------------------------------------------------
  // Memory wait FSM, wait counter, error flag and stall counter.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
`ifdef HAZ_MEM_TIMEOUT_EN
      mem_err_q   <= 1'b0;
`endif
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (MemReqM && !MemReadyM) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        S_WAIT: begin
          if (MemReadyM) begin
            state_q <= S_IDLE;
`ifdef HAZ_MEM_TIMEOUT_EN
          end else if (wait_cnt_q == TIMEOUT_LIM) begin
            state_q   <= S_ERR;
            mem_err_q <= 1'b1;
`endif
          end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        // ERR is left only through rst_n.
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pl_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pl_hazard_ctrl                                             |
// | Purpose  : Self-checking bench for pl_hazard_ctrl: a table of            |
// |            combinational vectors, hand-written multi-cycle sequences and |
// |            random stimulus against a behavioural reference model.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pl_hazard_ctrl;

`ifdef HAZ_MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam bit TB_TMO_EN  = 1'b1;
`else
  localparam int TB_TIMEOUT = 255;
  localparam bit TB_TMO_EN  = 1'b0;
`endif
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk, rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ResultSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] StallCnt;

  int errors = 0;
  int checks = 0;

  pl_hazard_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCnt(StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // ------------------------------------------------------------------
  // Vector table (applied while reset holds the FSM in IDLE).
  // ------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rse;
    logic       pcs;
    logic [1:0] fa, fb;
    logic       sf, fd, fe;
  } vec_t;

  function automatic vec_t mkv(input string n,
      input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
      input logic rwm, rww, input logic [1:0] rse, input logic pcs,
      input logic [1:0] fa, fb, input logic sf, fd, fe);
    vec_t v;
    v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww;
    v.rse = rse; v.pcs = pcs; v.fa = fa; v.fb = fb; v.sf = sf; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  vec_t tbl[$];

  // ------------------------------------------------------------------
  // Reference model: an outstanding-access flag with its elapsed wait
  // count, a sticky error flag and an integer stall tally.
  // ------------------------------------------------------------------
  bit m_pending, m_err;
  int m_wcnt, m_cnt;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_mem_stall();
    if (m_err) return 1'b1;
    if (m_pending) return !MemReadyM;
    return MemReqM && !MemReadyM;
  endfunction

  function automatic bit ref_lw_stall();
    return !ref_mem_stall() && !PCSrcE && ResultSrcE == 2'b01 && RdE != 0 &&
           (RdE == Rs1D || RdE == Rs2D);
  endfunction

  task automatic check_model(input string tag);
    bit ms, lw;
    ms = ref_mem_stall();
    lw = ref_lw_stall();
    chk({tag, "_ForwardAE"}, 32'(ForwardAE), 32'(ref_fwd(Rs1E)));
    chk({tag, "_ForwardBE"}, 32'(ForwardBE), 32'(ref_fwd(Rs2E)));
    chk({tag, "_StallF"}, 32'(StallF), 32'(ms | lw));
    chk({tag, "_StallD"}, 32'(StallD), 32'(ms | lw));
    chk({tag, "_StallE"}, 32'(StallE), 32'(ms));
    chk({tag, "_StallM"}, 32'(StallM), 32'(ms));
    chk({tag, "_FlushD"}, 32'(FlushD), 32'(PCSrcE & !ms));
    chk({tag, "_FlushE"}, 32'(FlushE), 32'((lw | PCSrcE) & !ms));
    chk({tag, "_FlushW"}, 32'(FlushW), 32'(ms));
    chk({tag, "_MemErr"}, 32'(MemErr), 32'(m_err));
    chk({tag, "_StallCnt"}, 32'(StallCnt), 32'(m_cnt));
  endtask

  task automatic model_edge();
    if (ref_mem_stall() || ref_lw_stall())
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    if (m_err) begin
    end else if (m_pending) begin
      if (MemReadyM) m_pending = 0;
      else if (TB_TMO_EN && m_wcnt >= TB_TIMEOUT) begin m_err = 1; m_pending = 0; end
      else m_wcnt = (m_wcnt < 255) ? m_wcnt + 1 : 255;
    end else if (MemReqM && !MemReadyM) begin
      m_pending = 1; m_wcnt = 1;
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    tbl.push_back(mkv("fwd_m_prio", 0,0,5,9,0,5,5, 1,1,2'b00,0, 2'b10,2'b00, 0,0,0));
    tbl.push_back(mkv("fwd_w",      0,0,5,9,0,5,5, 0,1,2'b00,0, 2'b01,2'b00, 0,0,0));
    tbl.push_back(mkv("fwd_x0",     0,0,0,0,0,0,0, 1,1,2'b00,0, 2'b00,2'b00, 0,0,0));
    tbl.push_back(mkv("fwd_b_w",    0,0,6,3,0,4,3, 1,1,2'b00,0, 2'b00,2'b01, 0,0,0));
    tbl.push_back(mkv("fwd_b_m",    0,0,3,4,0,4,4, 1,1,2'b00,0, 2'b00,2'b10, 0,0,0));
    tbl.push_back(mkv("lw_rs2",     0,7,0,0,7,0,0, 0,0,2'b01,0, 2'b00,2'b00, 1,0,1));
    tbl.push_back(mkv("lw_rd0",     0,0,0,0,0,0,0, 0,0,2'b01,0, 2'b00,2'b00, 0,0,0));
    tbl.push_back(mkv("lw_rs1",    12,0,0,0,12,0,0,0,0,2'b01,0, 2'b00,2'b00, 1,0,1));
    tbl.push_back(mkv("not_load",  12,0,0,0,12,0,0,0,0,2'b10,0, 2'b00,2'b00, 0,0,0));
    tbl.push_back(mkv("branch",     0,0,0,0,0,0,0, 0,0,2'b00,1, 2'b00,2'b00, 0,1,1));
    tbl.push_back(mkv("branch_lw",  0,7,0,0,7,0,0, 0,0,2'b01,1, 2'b00,2'b00, 0,1,1));

    #2;
    chk("reset_StallCnt", 32'(StallCnt), 32'd0);
    chk("reset_MemErr", 32'(MemErr), 32'd0);
    foreach (tbl[i]) begin
      Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
      RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
      RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww;
      ResultSrcE = tbl[i].rse; PCSrcE = tbl[i].pcs;
      #1;
      chk({tbl[i].name, "_fa"}, 32'(ForwardAE), 32'(tbl[i].fa));
      chk({tbl[i].name, "_fb"}, 32'(ForwardBE), 32'(tbl[i].fb));
      chk({tbl[i].name, "_stallF"}, 32'(StallF), 32'(tbl[i].sf));
      chk({tbl[i].name, "_stallD"}, 32'(StallD), 32'(tbl[i].sf));
      chk({tbl[i].name, "_stallE"}, 32'(StallE), 32'd0);
      chk({tbl[i].name, "_flushD"}, 32'(FlushD), 32'(tbl[i].fd));
      chk({tbl[i].name, "_flushE"}, 32'(FlushE), 32'(tbl[i].fe));
      chk({tbl[i].name, "_flushW"}, 32'(FlushW), 32'd0);
      chk({tbl[i].name, "_cnt"}, 32'(StallCnt), 32'd0);
    end
    clear_inputs();
    @(negedge clk); rst_n = 1'b1;

    // Memory access with three wait cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); MemReqM = 1; MemReadyM = 0; #1;
      chk("memwait_stallF", 32'(StallF), 32'd1);
      chk("memwait_stallM", 32'(StallM), 32'd1);
      chk("memwait_flushW", 32'(FlushW), 32'd1);
    end
    @(negedge clk); MemReadyM = 1; #1;
    chk("memwait_release_stallF", 32'(StallF), 32'd0);
    chk("memwait_release_flushW", 32'(FlushW), 32'd0);
    @(negedge clk); MemReqM = 0; MemReadyM = 0; #1;
    chk("memwait_idle_stallF", 32'(StallF), 32'd0);
    chk("memwait_cnt", 32'(StallCnt), 32'd3);

    // Ready in the request cycle: no stall, stays idle.
    @(negedge clk); MemReqM = 1; MemReadyM = 1; #1;
    chk("memfast_stallF", 32'(StallF), 32'd0);
    @(negedge clk); MemReqM = 0; MemReadyM = 0; #1;
    chk("memfast_idle_stallE", 32'(StallE), 32'd0);
    chk("memfast_cnt", 32'(StallCnt), 32'd3);

    // Load-use: one bubble cycle.
    @(negedge clk); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
    chk("lwuse_stallF", 32'(StallF), 32'd1);
    chk("lwuse_flushE", 32'(FlushE), 32'd1);
    @(negedge clk); clear_inputs(); #1;
    chk("lwuse_cnt", 32'(StallCnt), 32'd4);

    // Taken branch does not count as a stall.
    @(negedge clk); PCSrcE = 1; #1;
    chk("branch_flushD", 32'(FlushD), 32'd1);
    chk("branch_stallF", 32'(StallF), 32'd0);
    @(negedge clk); clear_inputs(); #1;
    chk("branch_cnt", 32'(StallCnt), 32'd4);

    // Branch during a two-cycle memory wait.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); MemReqM = 1; MemReadyM = 0; PCSrcE = 1; #1;
      chk("brwait_flushD", 32'(FlushD), 32'd0);
      chk("brwait_flushE", 32'(FlushE), 32'd0);
      chk("brwait_stallF", 32'(StallF), 32'd1);
    end
    @(negedge clk); MemReadyM = 1; #1;
    chk("brwait_end_flushD", 32'(FlushD), 32'd1);
    chk("brwait_end_flushE", 32'(FlushE), 32'd1);
    @(negedge clk); clear_inputs(); #1;
    chk("brwait_cnt", 32'(StallCnt), 32'd6);

    // Reset asserted in the middle of a wait.
    @(negedge clk); MemReqM = 1; MemReadyM = 0;
    @(negedge clk); MemReqM = 0; #1;
    chk("rstwait_in_wait", 32'(StallF), 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("rstwait_stallF", 32'(StallF), 32'd0);
    chk("rstwait_flushW", 32'(FlushW), 32'd0);
    chk("rstwait_cnt", 32'(StallCnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Random stimulus against the reference model.
    m_pending = 0; m_err = 0; m_wcnt = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 4) == 0);
      MemReqM = ($urandom_range(0, 2) == 0);
      MemReadyM = ($urandom_range(0, 2) != 0);
      #1;
      check_model("rand");
      @(posedge clk);
      model_edge();
    end

`ifdef HAZ_MEM_TIMEOUT_EN
    @(negedge clk); clear_inputs(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); MemReqM = 1; MemReadyM = 0; #1;
      chk("tmo_before_err", 32'(MemErr), 32'd0);
    end
    @(negedge clk); #1;
    chk("tmo_memerr", 32'(MemErr), 32'd1);
    MemReadyM = 1; MemReqM = 0; #1;
    chk("tmo_err_stallF", 32'(StallF), 32'd1);
    chk("tmo_err_flushW", 32'(FlushW), 32'd1);
    @(negedge clk); #1;
    chk("tmo_sticky", 32'(MemErr), 32'd1);
    rst_n = 1'b0; #1;
    chk("tmo_rst_clear", 32'(MemErr), 32'd0);
    @(negedge clk); rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
